// File: rtl/inst_encoder_loader_pkg.sv
// Shared RV32I encoding constants and loader FSM state type, used by both the
// instruction-type decoder and the encoder/loader.
package inst_encoder_loader_pkg;

  localparam logic [2:0] TYPE_I = 3'd0;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;
  localparam logic [2:0] TYPE_R = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } loader_state_e;

  // Returns {known, type} for an opcode as the core decodes it.
  function automatic logic [3:0] opcode_class(input logic [6:0] opc);
    case (opc)
      OPC_OP:                           opcode_class = {1'b1, TYPE_R};
      OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: opcode_class = {1'b1, TYPE_I};
      OPC_STORE:                        opcode_class = {1'b1, TYPE_S};
      OPC_BRANCH:                       opcode_class = {1'b1, TYPE_B};
      OPC_JAL:                          opcode_class = {1'b1, TYPE_J};
      OPC_AUIPC, OPC_LUI:               opcode_class = {1'b1, TYPE_U};
      default:                          opcode_class = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/inst_word_packer.sv
// Combinational packer: type code + fields -> RV32I word and illegal flag.
// Optional opcode/type cross-check under INST_ENCODER_TYPE_CHECK_EN.
module inst_word_packer
  import inst_encoder_loader_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

`ifdef INST_ENCODER_TYPE_CHECK_EN
  logic [3:0] opc_class;
  assign opc_class = opcode_class(opcode);
`endif

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_type)
      TYPE_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      TYPE_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      TYPE_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      TYPE_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      TYPE_U: word = {imm[31:12], rd, opcode};
      TYPE_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
`ifdef INST_ENCODER_TYPE_CHECK_EN
    if (opc_class != {1'b1, op_type}) illegal = 1'b1;
`endif
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Packs field-level instruction bundles into RV32I words and streams them to
// instruction memory at consecutive addresses. Option: INST_ENCODER_TYPE_CHECK_EN.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        op_type,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              out_vld_q, out_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [31:0] packed_word;
  logic        packed_illegal;
  logic        wr_acc;
  logic        in_acc;
  logic        in_ready_c;

  inst_word_packer u_packer (
    .op_type (op_type),
    .opcode  (opcode),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  assign wr_acc     = out_vld_q && mem_ready;
  assign in_ready_c = (state_q == ST_RUN) && (!out_vld_q || mem_ready);
  assign in_acc     = in_valid && in_ready_c;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    out_vld_d = out_vld_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;

    // mem_addr is the address of the word currently held; it advances on write.
    if (wr_acc) begin
      addr_d    = addr_q + ADDR_W'(4);
      cnt_d     = cnt_q + CNT_W'(1);
      out_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base_addr & ~ADDR_W'(3);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (in_acc) begin
          if (packed_illegal) begin
            err_d = 1'b1;
          end else begin
            out_vld_d = 1'b1;
            wdata_d   = packed_word;
          end
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_vld_q || wr_acc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign mem_we    = out_vld_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign wr_count  = cnt_q;
  assign err       = err_q;

endmodule
